// File: rtl/alu_mc.sv
// Multi-cycle ALU. Single-cycle ops finish in one clock. MUL/MULHU/DIVU/REMU
// iterate one bit per clock over a shared 2*WIDTH working register.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start; operands latched when start is accepted
//   S_RUN  | iterative multiply/divide, WIDTH cycles, start ignored
//   S_DONE | one-cycle done pulse, result/flags valid, start ignored
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SVW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_op,
    input  logic             imm_mux,
    input  logic [1:0]       branch,
    input  logic [SVW-1:0]   sv,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             branch_taken,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int AW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nx;
    logic [4:0]         op_q;
    logic [1:0]         br_q;
    logic [WIDTH-1:0]   a_q, b_q, c3_q;
    logic [2*WIDTH-1:0] p_q, p_nx;
    logic [AW-1:0]      cnt;

    logic [WIDTH-1:0]   b_in, b_sh, sc_res, mc_res;
    logic [AW-1:0]      rot_amt;
    logic [WIDTH:0]     sum, mul_sum, div_sh, div_diff;
    logic               sc_ovf, dz, is_mc;

    function automatic logic br_eval(input logic [1:0] mode,
                                     input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
        case (mode)
            2'b01:   br_eval = (x == y);
            2'b10:   br_eval = (x != y);
            2'b11:   br_eval = 1'b1;
            default: br_eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        b_in    = imm_mux ? imm : in2;
        b_sh    = b_in << sv;
        rot_amt = b_in[AW-1:0];
        sum     = '0;
        sc_res  = '0;
        sc_ovf  = 1'b0;
        case (alu_op)
            5'd0: begin
                sum    = {1'b0, in1} + {1'b0, b_in};
                sc_res = sum[WIDTH-1:0];
                sc_ovf = sum[WIDTH];
            end
            5'd1: begin
                sc_res = in1 - b_in;
                sc_ovf = (in1 < b_in);
            end
            5'd2:  sc_res = in1 & b_in;
            5'd3:  sc_res = in1 | b_in;
            5'd4:  sc_res = in1 ^ b_in;
            5'd5:  sc_res = (b_in >= WIDTH'(WIDTH)) ? '0 : (in1 >> b_in);
            5'd6:  sc_res = (b_in >= WIDTH'(WIDTH)) ? '0 : (in1 << b_in);
            // A left shift by exactly WIDTH yields 0, so amount 0 returns A.
            5'd7:  sc_res = (in1 >> rot_amt) | (in1 << (WIDTH'(WIDTH) - WIDTH'(rot_amt)));
            5'd8:  sc_res = b_in;
            5'd9: begin
                sum    = {1'b0, in1} + {1'b0, b_sh};
                sc_res = sum[WIDTH-1:0];
                sc_ovf = sum[WIDTH];
            end
            5'd10: begin
                sum    = {1'b0, pc} + {1'b0, b_in};
                sc_res = sum[WIDTH-1:0];
                sc_ovf = sum[WIDTH];
            end
            5'd13: sc_res = '1;
            5'd14: sc_res = in1;
            default: sc_res = '0;
        endcase
    end

    assign dz    = ((alu_op == 5'd13) || (alu_op == 5'd14)) && (b_in == '0);
    assign is_mc = (alu_op >= 5'd11) && (alu_op <= 5'd14) && !dz;

    // p_q: upper half is the partial product / remainder, lower half the
    // multiplier bits still to consume / dividend bits turning into quotient.
    always_comb begin
        mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_q};
        if ((op_q == 5'd11) || (op_q == 5'd12))
            p_nx = {mul_sum, p_q[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            p_nx = {div_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        else
            p_nx = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        if ((op_q == 5'd11) || (op_q == 5'd13))
            mc_res = p_nx[WIDTH-1:0];
        else
            mc_res = p_nx[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = is_mc ? S_RUN : S_DONE;
            S_RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= '0;
            br_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c3_q         <= '0;
            p_q          <= '0;
            cnt          <= '0;
            result       <= '0;
            overflow     <= 1'b0;
            branch_taken <= 1'b0;
            div_by_zero  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) begin
                    op_q <= alu_op;
                    br_q <= branch;
                    a_q  <= in1;
                    b_q  <= b_in;
                    c3_q <= in3;
                    p_q  <= {{WIDTH{1'b0}}, in1};
                    cnt  <= AW'(WIDTH - 1);
                    if (!is_mc) begin
                        result       <= sc_res;
                        overflow     <= sc_ovf;
                        branch_taken <= br_eval(branch, in3, in1);
                        div_by_zero  <= dz;
                    end
                end
                S_RUN: begin
                    p_q <= p_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result       <= mc_res;
                        overflow     <= 1'b0;
                        branch_taken <= br_eval(br_q, c3_q, a_q);
                        div_by_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit and an 8-bit instance share the stimulus buses.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, start8 = 1'b0;
    logic [4:0]  alu_op = '0;
    logic        imm_mux = 1'b0;
    logic [1:0]  branch = '0, sv = '0;
    logic [31:0] in1 = '0, in2 = '0, in3 = '0, imm = '0, pc = '0;
    logic [31:0] result;
    logic        overflow, branch_taken, busy, done, div_by_zero;
    logic [7:0]  result8;
    logic        overflow8, branch_taken8, busy8, done8, div_by_zero8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32), .SVW(2)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .imm_mux(imm_mux),
        .branch(branch), .sv(sv), .in1(in1), .in2(in2), .in3(in3), .imm(imm), .pc(pc),
        .result(result), .overflow(overflow), .branch_taken(branch_taken),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    alu_mc #(.WIDTH(8), .SVW(2)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .alu_op(alu_op), .imm_mux(imm_mux),
        .branch(branch), .sv(sv), .in1(in1[7:0]), .in2(in2[7:0]), .in3(in3[7:0]),
        .imm(imm[7:0]), .pc(pc[7:0]),
        .result(result8), .overflow(overflow8), .branch_taken(branch_taken8),
        .busy(busy8), .done(done8), .div_by_zero(div_by_zero8)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        imux;
        logic [31:0] immv;
        logic [1:0]  s;
        logic [31:0] pcv;
        logic [31:0] er;
        logic        eo;
    } vec_t;

    task automatic issue(input bit w8, input logic [4:0] op, input logic [31:0] a, b,
                         input logic imux, input logic [31:0] immv, input logic [1:0] s,
                         input logic [1:0] br, input logic [31:0] c3, pcv);
        for (int k = 0; k < 100 && (busy || done || busy8 || done8); k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        alu_op = op; in1 = a; in2 = b; imm_mux = imux; imm = immv;
        sv = s; branch = br; in3 = c3; pc = pcv;
        if (w8) start8 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start8 = 1'b0;
    endtask

    task automatic wait_done(input bit w8, output int lat, output int bcnt);
        lat = 1; bcnt = 0;
        while (((w8 ? done8 : done) !== 1'b1) && lat < 200) begin
            if ((w8 ? busy8 : busy) === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({result, overflow, branch_taken, div_by_zero, busy, done} !== 37'b0) begin
            errors++;
            $display("FAIL reset32: result=%h ovf=%b bt=%b dbz=%b busy=%b done=%b, want all 0",
                     result, overflow, branch_taken, div_by_zero, busy, done);
        end
        checks++;
        if ({result8, overflow8, branch_taken8, div_by_zero8, busy8, done8} !== 13'b0) begin
            errors++;
            $display("FAIL reset8: result=%h ovf=%b bt=%b dbz=%b busy=%b done=%b, want all 0",
                     result8, overflow8, branch_taken8, div_by_zero8, busy8, done8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        vec_t v [0:20];
        int lat, bc;
        v[0]  = '{5'd0,  32'hFFFF_FFFF, 32'd1,          1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0000, 1'b1};
        v[1]  = '{5'd1,  32'd3,         32'd5,          1'b0, 32'd0,          2'd0, 32'd0,          32'hFFFF_FFFE, 1'b1};
        v[2]  = '{5'd1,  32'd5,         32'd3,          1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0002, 1'b0};
        v[3]  = '{5'd2,  32'h0000_F0F0, 32'h0000_FF00,  1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_F000, 1'b0};
        v[4]  = '{5'd3,  32'h0000_F0F0, 32'h0000_FF00,  1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_FFF0, 1'b0};
        v[5]  = '{5'd4,  32'h0000_F0F0, 32'h0000_FF00,  1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0FF0, 1'b0};
        v[6]  = '{5'd5,  32'h8000_0000, 32'd31,         1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0001, 1'b0};
        v[7]  = '{5'd5,  32'h8000_0000, 32'd32,         1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0000, 1'b0};
        v[8]  = '{5'd6,  32'd1,         32'd4,          1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0010, 1'b0};
        v[9]  = '{5'd6,  32'd1,         32'd32,         1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0000, 1'b0};
        v[10] = '{5'd7,  32'd1,         32'd0,          1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0001, 1'b0};
        v[11] = '{5'd7,  32'd1,         32'd1,          1'b0, 32'd0,          2'd0, 32'd0,          32'h8000_0000, 1'b0};
        v[12] = '{5'd7,  32'd1,         32'd33,         1'b0, 32'd0,          2'd0, 32'd0,          32'h8000_0000, 1'b0};
        v[13] = '{5'd8,  32'd9,         32'd5,          1'b1, 32'd1234,       2'd0, 32'd0,          32'd1234,      1'b0};
        v[14] = '{5'd9,  32'd10,        32'd100,        1'b1, 32'd3,          2'd2, 32'd0,          32'h0000_0016, 1'b0};
        v[15] = '{5'd9,  32'hFFFF_FFFF, 32'd0,          1'b1, 32'd1,          2'd1, 32'd0,          32'h0000_0001, 1'b1};
        v[16] = '{5'd9,  32'd0,         32'd0,          1'b1, 32'hC000_0001,  2'd2, 32'd0,          32'h0000_0004, 1'b0};
        v[17] = '{5'd10, 32'hFFFF_FFFF, 32'd4,          1'b0, 32'd0,          2'd0, 32'h0000_0100,  32'h0000_0104, 1'b0};
        v[18] = '{5'd10, 32'd0,         32'd1,          1'b0, 32'd0,          2'd0, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1};
        v[19] = '{5'd20, 32'd5,         32'd5,          1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0000, 1'b0};
        v[20] = '{5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'd0,          2'd0, 32'd0,          32'h0000_0000, 1'b0};
        for (int i = 0; i <= 20; i++) begin
            issue(1'b0, v[i].op, v[i].a, v[i].b, v[i].imux, v[i].immv, v[i].s, 2'b00, 32'd0, v[i].pcv);
            wait_done(1'b0, lat, bc);
            checks++;
            if (result !== v[i].er) begin
                errors++;
                $display("FAIL single[%0d] op=%0d result: got %h want %h", i, v[i].op, result, v[i].er);
            end
            checks++;
            if ({lat, overflow, div_by_zero} !== {32'd1, v[i].eo, 1'b0}) begin
                errors++;
                $display("FAIL single[%0d] op=%0d lat/ovf/dbz: got %0d/%b/%b want 1/%b/0",
                         i, v[i].op, lat, overflow, div_by_zero, v[i].eo);
            end
        end
        // done must be a single-cycle pulse and the result must hold afterwards
        @(posedge clk); #1;
        checks++;
        if ({done, result} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL done_pulse: done=%b result=%h want done=0 result=0", done, result);
        end
    endtask

    task automatic test_branch;
        logic [1:0]  md [0:5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [31:0] c3 [0:5] = '{32'd5, 32'd6, 32'd6, 32'd5, 32'd9, 32'd5};
        logic        eb [0:5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 5'd15, 32'd5, 32'd1, 1'b0, 32'd0, 2'd0, md[i], c3[i], 32'd0);
            wait_done(1'b0, lat, bc);
            checks++;
            if ({branch_taken, result, lat} !== {eb[i], 32'd0, 32'd1}) begin
                errors++;
                $display("FAIL branch[%0d] mode=%b: bt=%b result=%h lat=%0d want bt=%b result=0 lat=1",
                         i, md[i], branch_taken, result, lat, eb[i]);
            end
        end
    endtask

    task automatic test_mul;
        int lat, bc;
        issue(1'b0, 5'd11, 32'd7, 32'd6, 1'b0, 32'd0, 2'd0, 2'b01, 32'd7, 32'd0);
        wait_done(1'b0, lat, bc);
        checks++;
        if ({lat, bc} !== {32'd33, 32'd32}) begin
            errors++;
            $display("FAIL mul_timing: lat=%0d busy_cycles=%0d want 33/32", lat, bc);
        end
        checks++;
        if ({result, overflow, branch_taken, div_by_zero} !== {32'd42, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mul_7x6: result=%h ovf=%b bt=%b dbz=%b want 0000002a/0/1/0",
                     result, overflow, branch_taken, div_by_zero);
        end
        issue(1'b0, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
        wait_done(1'b0, lat, bc);
        checks++;
        if ({result, lat, branch_taken} !== {32'hFFFF_FFFE, 32'd33, 1'b0}) begin
            errors++;
            $display("FAIL mulhu_max: result=%h lat=%0d bt=%b want fffffffe/33/0", result, lat, branch_taken);
        end
        issue(1'b0, 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
        wait_done(1'b0, lat, bc);
        checks++;
        if (result !== 32'h0000_0001) begin
            errors++;
            $display("FAIL mul_max_low: result=%h want 00000001", result);
        end
    endtask

    task automatic test_div;
        logic [4:0]  op [0:6] = '{5'd13, 5'd14, 5'd13, 5'd14, 5'd13, 5'd13, 5'd14};
        logic [31:0] a  [0:6] = '{32'd100, 32'd100, 32'd100, 32'd100, 32'd100, 32'hFFFF_FFFF, 32'd7};
        logic [31:0] b  [0:6] = '{32'd7, 32'd7, 32'd0, 32'd0, 32'd7, 32'd1, 32'd100};
        logic [31:0] er [0:6] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd100, 32'd14, 32'hFFFF_FFFF, 32'd7};
        logic        ez [0:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          el [0:6] = '{33, 33, 1, 1, 33, 33, 33};
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            issue(1'b0, op[i], a[i], b[i], 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
            wait_done(1'b0, lat, bc);
            checks++;
            if ({result, div_by_zero, overflow, lat} !== {er[i], ez[i], 1'b0, el[i]}) begin
                errors++;
                $display("FAIL div[%0d] op=%0d %0d/%0d: result=%h dbz=%b ovf=%b lat=%0d want %h/%b/0/%0d",
                         i, op[i], a[i], b[i], result, div_by_zero, overflow, lat, er[i], ez[i], el[i]);
            end
        end
    endtask

    task automatic test_abort;
        int lat, bc;
        bit seen_done = 1'b0;
        issue(1'b0, 5'd13, 32'd100, 32'd7, 1'b0, 32'd0, 2'd0, 2'b11, 32'd0, 32'd0);
        repeat (9) begin
            if (done) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (done) seen_done = 1'b1;
        checks++;
        if ({result, overflow, branch_taken, div_by_zero, busy, done, seen_done} !== 38'b0) begin
            errors++;
            $display("FAIL abort: result=%h ovf=%b bt=%b dbz=%b busy=%b done=%b seen_done=%b want all 0",
                     result, overflow, branch_taken, div_by_zero, busy, done, seen_done);
        end
        rst = 1'b0;
        issue(1'b0, 5'd0, 32'd2, 32'd3, 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
        wait_done(1'b0, lat, bc);
        checks++;
        if ({result, lat} !== {32'd5, 32'd1}) begin
            errors++;
            $display("FAIL after_abort: result=%h lat=%0d want 00000005/1", result, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(1'b0, 5'd11, 32'd7, 32'd6, 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
        in1 = 32'd100; in2 = 32'd100; alu_op = 5'd0; start = 1'b1;
        wait_done(1'b0, lat, bc);
        checks++;
        if ({result, lat} !== {32'd42, 32'd33}) begin
            errors++;
            $display("FAIL busy_ignore: result=%h lat=%0d want 0000002a/33", result, lat);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done, result} !== {1'b0, 1'b0, 32'd42}) begin
            errors++;
            $display("FAIL done_ignore: busy=%b done=%b result=%h want 0/0/0000002a", busy, done, result);
        end
        issue(1'b0, 5'd0, 32'd5, 32'd5, 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
        wait_done(1'b0, lat, bc);
        checks++;
        if ({result, lat} !== {32'd10, 32'd1}) begin
            errors++;
            $display("FAIL next_op: result=%h lat=%0d want 0000000a/1", result, lat);
        end
    endtask

    task automatic test_width8;
        logic [4:0] op [0:6] = '{5'd0, 5'd11, 5'd12, 5'd13, 5'd14, 5'd7, 5'd5};
        logic [7:0] a  [0:6] = '{8'hFF, 8'd7, 8'hFF, 8'd100, 8'd100, 8'h01, 8'hFF};
        logic [7:0] b  [0:6] = '{8'h01, 8'd6, 8'hFF, 8'd7, 8'd7, 8'd9, 8'd8};
        logic [7:0] er [0:6] = '{8'h00, 8'h2A, 8'hFE, 8'h0E, 8'h02, 8'h80, 8'h00};
        logic       eo [0:6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int         el [0:6] = '{1, 9, 9, 9, 9, 1, 1};
        int         eb [0:6] = '{0, 8, 8, 8, 8, 0, 0};
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            issue(1'b1, op[i], {24'd0, a[i]}, {24'd0, b[i]}, 1'b0, 32'd0, 2'd0, 2'b00, 32'd0, 32'd0);
            wait_done(1'b1, lat, bc);
            checks++;
            if ({result8, overflow8, lat, bc} !== {er[i], eo[i], el[i], eb[i]}) begin
                errors++;
                $display("FAIL w8[%0d] op=%0d: result=%h ovf=%b lat=%0d busy=%0d want %h/%b/%0d/%0d",
                         i, op[i], result8, overflow8, lat, bc, er[i], eo[i], el[i], eb[i]);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_branch;
        test_mul;
        test_div;
        test_abort;
        test_back_to_back;
        test_width8;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
